// File: rtl/smg_pkg.sv
// Shared types and constants for the binary-to-BCD converter feeding the seven-segment scanner.
package smg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_BLANK     = 4'hF;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Largest value representable in the given number of decimal digits (10^digits - 1).
  function automatic longint unsigned smg_limit(input int unsigned digits);
    longint unsigned v;
    v = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/smg_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more.
module smg_bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted_c
);

  // Input never exceeds 9, so the 4-bit sum cannot carry out.
  assign adjusted_c = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/smg_bin2bcd_module.sv
// Iterative binary-to-packed-BCD converter with start/done handshake and saturation.
// Optional leading-zero blanking is enabled by defining SMG_LEADING_BLANK_EN.
module smg_bin2bcd_module
  import smg_pkg::*;
#(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  CLOCK,
  input  logic                  RST,
  input  logic                  Start_Sig,
  input  logic [BIN_W-1:0]      Bin_Data,
  output logic                  Busy_Sig,
  output logic                  Done_Sig,
  output logic                  Ovf_Sig,
  output logic [4*DIGITS-1:0]   Number_Sig
);

  localparam int unsigned     NUM_W = 4 * DIGITS;
  localparam int unsigned     CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned LIMIT = smg_limit(DIGITS);
  localparam logic [NUM_W-1:0] SAT_VALUE = {DIGITS{BCD_MAX_DIGIT}};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BIN_W-1:0]   data_q, data_d;
  logic [NUM_W-1:0]   number_q, number_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;

  logic [NUM_W-1:0]   bcd_adj_c;
  logic [NUM_W-1:0]   blank_c;
  logic               sat_c;

  // Per-digit +3 correction applied before each shift.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
    smg_bcd_add3 u_add3 (
      .digit      (bcd_q[4*g +: 4]),
      .adjusted_c (bcd_adj_c[4*g +: 4])
    );
  end

  assign sat_c = 64'(data_q) > LIMIT;

`ifdef SMG_LEADING_BLANK_EN
  logic lead_c;

  // Blank zero digits from the MSD down until the first non-zero; digit 0 always shows.
  always_comb begin
    blank_c = bcd_q;
    lead_c  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead_c && (bcd_q[4*i +: 4] == 4'd0)) begin
        blank_c[4*i +: 4] = BCD_BLANK;
      end else begin
        lead_c = 1'b0;
      end
    end
  end
`else
  assign blank_c = bcd_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    data_d   = data_q;
    number_d = number_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (Start_Sig) begin
          bin_d   = Bin_Data;
          data_d  = Bin_Data;
          bcd_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj_c[NUM_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        number_d = sat_c ? SAT_VALUE : blank_c;
        ovf_d    = sat_c;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bcd_q    <= '0;
      bin_q    <= '0;
      data_q   <= '0;
      number_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      data_q   <= data_d;
      number_q <= number_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Number_Sig = number_q;
  assign Done_Sig   = done_q;
  assign Busy_Sig   = busy_q;
  assign Ovf_Sig    = ovf_q;

endmodule

// File: tb/tb_smg_bin2bcd_module.sv
// Scoreboard bench for smg_bin2bcd_module: decimal reference model, decoupled done monitor.
module tb_smg_bin2bcd_module;

  localparam int unsigned BIN_W = 20;
  localparam int unsigned LAT   = 21;

  logic        CLOCK = 1'b0;
  logic        RST = 1'b1;
  logic        Start_Sig = 1'b0;
  logic [19:0] Bin_Data = '0;
  logic        Busy_Sig;
  logic        Done_Sig;
  logic        Ovf_Sig;
  logic [23:0] Number_Sig;

  typedef struct {
    logic [23:0] number;
    logic        ovf;
    int          start_cyc;
    int unsigned value;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  logic        rst_edge = 1'b1;
  logic [23:0] last_num = '0;
  logic        last_ovf = 1'b0;

  smg_bin2bcd_module #(.BIN_W(20), .DIGITS(6)) dut (
    .CLOCK      (CLOCK),
    .RST        (RST),
    .Start_Sig  (Start_Sig),
    .Bin_Data   (Bin_Data),
    .Busy_Sig   (Busy_Sig),
    .Done_Sig   (Done_Sig),
    .Ovf_Sig    (Ovf_Sig),
    .Number_Sig (Number_Sig)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    cyc      <= cyc + 1;
    rst_edge <= RST;
  end

  // Reference: decimal digits by division, saturate above 999999, optional leading blanks.
  function automatic logic [24:0] model(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    bit          lead;
    if (v > 999999) return {1'b1, 24'h999999};
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef SMG_LEADING_BLANK_EN
    lead = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return {1'b0, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops on every Done_Sig, otherwise the outputs must hold.
  always @(negedge CLOCK) begin
    if (Done_Sig === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got Done_Sig=1 expected no conversion pending (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("number(%0d)", mon_e.value), 32'(Number_Sig), 32'(mon_e.number));
        check($sformatf("ovf(%0d)", mon_e.value), 32'(Ovf_Sig), 32'(mon_e.ovf));
        check("latency", 32'(cyc - mon_e.start_cyc), 32'(LAT));
        check("busy_at_done", 32'(Busy_Sig), 32'd0);
      end
    end else if (!rst_edge) begin
      check("number_hold", 32'(Number_Sig), 32'(last_num));
      check("ovf_hold", 32'(Ovf_Sig), 32'(last_ovf));
    end
    last_num = Number_Sig;
    last_ovf = Ovf_Sig;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  // Issue a start that the model knows will be accepted; scramble Bin_Data afterwards.
  task automatic start_conv(input int unsigned v);
    exp_t        e;
    logic [24:0] m;
    m           = model(v);
    e.number    = m[23:0];
    e.ovf       = m[24];
    e.start_cyc = cyc + 1;
    e.value     = v;
    sb.push_back(e);
    Start_Sig = 1'b1;
    Bin_Data  = 20'(v);
    @(posedge CLOCK);
    #1;
    Start_Sig = 1'b0;
    Bin_Data  = 20'($urandom);
    check("busy_after_start", 32'(Busy_Sig), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_number"}, 32'(Number_Sig), 32'd0);
    check({tag, "_done"}, 32'(Done_Sig), 32'd0);
    check({tag, "_busy"}, 32'(Busy_Sig), 32'd0);
    check({tag, "_ovf"}, 32'(Ovf_Sig), 32'd0);
  endtask

  int unsigned directed[7] = '{123456, 999999, 1000000, 1048575, 0, 7, 305};

  initial begin
    RST = 1'b1;
    idle(2);
    check_reset_outputs("reset");
    RST = 1'b0;
    idle(1);

    // Back-to-back directed conversions at full throughput.
    foreach (directed[i]) begin
      start_conv(directed[i]);
      idle(LAT);
    end

    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) start_conv($urandom_range(0, 999));
      else start_conv($urandom_range(0, (1 << BIN_W) - 1));
      idle(LAT + int'($urandom_range(0, 3)));
    end

    // A start during SHIFT is dropped; the same value converts after Done.
    start_conv(42);
    idle(4);
    Start_Sig = 1'b1;
    Bin_Data  = 20'd77;
    idle(1);
    Start_Sig = 1'b0;
    idle(16);
    start_conv(77);
    idle(LAT);

    // Reset mid-conversion: no Done, outputs cleared, next conversion normal.
    Start_Sig = 1'b1;
    Bin_Data  = 20'd555555;
    idle(1);
    Start_Sig = 1'b0;
    idle(9);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check_reset_outputs("abort");
    idle(30);
    start_conv(555555);
    idle(LAT + 5);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
